// File: rtl/layer_mem_sched_pkg.sv
// rtl/layer_mem_sched_pkg.sv - shared indices, FSM encoding and select constants
package layer_mem_sched_pkg;

  localparam int REQ_CONV = 0;
  localparam int REQ_POOL = 1;
  localparam int REQ_FLAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV    = 3'd1,
    ST_DRAIN_C = 3'd2,
    ST_PF      = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [2:0] CSEL_NONE = 3'd0;
  localparam logic [2:0] CSEL_L0   = 3'd1;
  localparam logic [2:0] CSEL_L1   = 3'd3;

  localparam logic [2:0] ELIG_CONV = 3'b001;
  localparam logic [2:0] ELIG_PF   = 3'b110;

  typedef logic [1:0] req_idx_t;

  // Successor in the 0 -> 1 -> 2 -> 0 round-robin ring.
  function automatic req_idx_t rr_next(input req_idx_t i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/layer_mem_sched_rr_arbiter3.sv
// rtl/layer_mem_sched_rr_arbiter3.sv - three-way round-robin pick with pointer register
module rr_arbiter3
  import layer_mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output req_idx_t   idx_o,
  output logic       valid_o
);

  req_idx_t ptr_q, ptr_d;
  req_idx_t cand0, cand1;

  always_comb begin
    cand0   = rr_next(ptr_q);
    cand1   = rr_next(cand0);
    valid_o = |req_i;
    idx_o   = ptr_q;
    if (req_i[cand0]) begin
      idx_o = cand0;
    end else if (req_i[cand1]) begin
      idx_o = cand1;
    end
    gnt_o = valid_o ? (3'b001 << idx_o) : 3'b000;
    ptr_d = valid_o ? idx_o : ptr_q;
  end

  // Pointer starts at 2 so requester 0 is searched first after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 2'd2;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/layer_mem_sched.sv
// rtl/layer_mem_sched.sv - phase sequencer and shared layer-memory port arbiter
module layer_mem_sched
  import layer_mem_sched_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 20,
  parameter int SEL_W   = 3,
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ready,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        start,
  input  logic [NUM_REQ-1:0]        done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*SEL_W-1:0]  sel,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      cwr,
  output logic [ADDR_W-1:0]         caddr_wr,
  output logic [DATA_W-1:0]         cdata_wr,
  output logic                      crd,
  output logic [ADDR_W-1:0]         caddr_rd,
  input  logic [DATA_W-1:0]         cdata_rd,
  output logic [SEL_W-1:0]          csel,
  output logic                      err
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   launch_q, launch_d;
  logic   [NUM_REQ-1:0] start_q, start_d;
  logic   [1:0] pfdone_q, pfdone_d;
  logic   err_q, err_d;

  logic   [NUM_REQ-1:0] elig, done_ok, arb_req;
  logic   [NUM_REQ-1:0] arb_gnt;
  req_idx_t win_idx;
  logic   win_valid;

  logic   [SEL_W-1:0]  sel_a   [NUM_REQ];
  logic   [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic   [DATA_W-1:0] wdata_a [NUM_REQ];

  logic               cwr_q, crd_q;
  logic [ADDR_W-1:0]  caddr_wr_q, caddr_rd_q;
  logic [DATA_W-1:0]  cdata_wr_q, rdata_q;
  logic [SEL_W-1:0]   csel_q;
  logic               rd_v1_q;
  req_idx_t           rd_tag1_q;
  logic [NUM_REQ-1:0] rvalid_q;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_a[k]   = sel[k*SEL_W +: SEL_W];
      addr_a[k]  = addr[k*ADDR_W +: ADDR_W];
      wdata_a[k] = wdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    launch_d = 1'b0;
    start_d  = {2'b00, launch_q};
    pfdone_d = pfdone_q;
    elig     = '0;
    done_ok  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d  = ST_CONV;
          busy_d   = 1'b1;
          launch_d = 1'b1;
        end
      end
      ST_CONV: begin
        elig    = ELIG_CONV;
        done_ok = ELIG_CONV;
        if (done[REQ_CONV]) state_d = ST_DRAIN_C;
      end
      ST_DRAIN_C: begin
        // Pool/flatten launch only after the last conv read has returned.
        if (!rd_v1_q) begin
          state_d  = ST_PF;
          start_d  = ELIG_PF;
          pfdone_d = 2'b00;
        end
      end
      ST_PF: begin
        elig     = ELIG_PF;
        done_ok  = ELIG_PF;
        pfdone_d = pfdone_q | {done[REQ_FLAT], done[REQ_POOL]};
        if (&pfdone_d) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_v1_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arb_req = req & elig;
    err_d   = err_q | (|(req & ~elig)) | (|(done & ~done_ok));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      launch_q <= 1'b0;
      start_q  <= '0;
      pfdone_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      launch_q <= launch_d;
      start_q  <= start_d;
      pfdone_q <= pfdone_d;
      err_q    <= err_d;
    end
  end

  rr_arbiter3 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (arb_req),
    .gnt_o   (arb_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Memory controls register the winner; stage 1/2 carry the read owner to rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      caddr_rd_q <= '0;
      csel_q     <= '0;
      rd_v1_q    <= 1'b0;
      rd_tag1_q  <= 2'd0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      cwr_q     <= win_valid & we[win_idx];
      crd_q     <= win_valid & ~we[win_idx];
      csel_q    <= win_valid ? sel_a[win_idx] : SEL_W'(CSEL_NONE);
      rd_v1_q   <= win_valid & ~we[win_idx];
      rd_tag1_q <= win_idx;
      if (win_valid && we[win_idx]) begin
        caddr_wr_q <= addr_a[win_idx];
        cdata_wr_q <= wdata_a[win_idx];
      end
      if (win_valid && !we[win_idx]) begin
        caddr_rd_q <= addr_a[win_idx];
      end
      rvalid_q <= rd_v1_q ? (3'b001 << rd_tag1_q) : 3'b000;
      if (rd_v1_q) begin
        rdata_q <= cdata_rd;
      end
    end
  end

  assign busy     = busy_q;
  assign start    = start_q;
  assign gnt      = arb_gnt;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;
  assign err      = err_q;

endmodule

// File: tb/tb_layer_mem_sched.sv
// tb/tb_layer_mem_sched.sv - scoreboard bench for the layer-memory sequencer/arbiter
module tb_layer_mem_sched;
  import layer_mem_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [2:0]  start, done, req, we, gnt, rvalid;
  logic [8:0]  sel;
  logic [35:0] addr;
  logic [59:0] wdata;
  logic [19:0] rdata, cdata_wr, cdata_rd;
  logic        cwr, crd, err;
  logic [11:0] caddr_wr, caddr_rd;
  logic [2:0]  csel;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q_gnt[$], q_wr[$], q_rd[$], q_rv[$], q_start[$];

  layer_mem_sched #(.ADDR_W(12), .DATA_W(20), .SEL_W(3), .NUM_REQ(3)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .start(start), .done(done),
    .req(req), .we(we), .sel(sel), .addr(addr), .wdata(wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mdata(input logic [2:0] s, input logic [11:0] a);
    return {s, 5'h15, a};
  endfunction

  assign cdata_rd = crd ? mdata(csel, caddr_rd) : 20'h0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [127:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: actual=%0h required=none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input int k, input logic w, input logic [2:0] s,
                         input logic [11:0] a, input logic [19:0] d);
    we[k]           = w;
    sel[k*3 +: 3]   = s;
    addr[k*12 +: 12] = a;
    wdata[k*20 +: 20] = d;
  endtask

  task automatic wait_start(input logic [2:0] mask, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if ((start & mask) != 3'b000) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    cmp(name, 128'(seen), 128'(1'b1));
    tick();
  endtask

  // Monitor: every presented output is matched against the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != 3'b000) begin
        if (q_gnt.size() == 0) unexp("gnt", 128'(gnt));
        else cmp("gnt", 128'(gnt), 128'(q_gnt.pop_front()));
      end
      if (cwr) begin
        if (q_wr.size() == 0) unexp("write_port", 128'({caddr_wr, cdata_wr, csel, crd}));
        else cmp("write_port", 128'({caddr_wr, cdata_wr, csel, crd}), 128'({q_wr.pop_front(), 1'b0}));
      end
      if (crd) begin
        if (q_rd.size() == 0) unexp("read_port", 128'({caddr_rd, csel, cwr}));
        else cmp("read_port", 128'({caddr_rd, csel, cwr}), 128'({q_rd.pop_front(), 1'b0}));
      end
      if (rvalid != 3'b000) begin
        if (q_rv.size() == 0) unexp("rvalid", 128'({rvalid, rdata}));
        else cmp("rvalid", 128'({rvalid, rdata}), 128'(q_rv.pop_front()));
      end
      if (start != 3'b000) begin
        if (q_start.size() == 0) unexp("start", 128'(start));
        else cmp("start", 128'(start), 128'(q_start.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_i, f_i, c_used;
    logic [11:0] p_addr[2];
    logic [11:0] f_addr[2];
    p_addr[0] = 12'h000; p_addr[1] = 12'h002;
    f_addr[0] = 12'h001; f_addr[1] = 12'h003;

    reset = 1'b1; ready = 1'b0; done = '0; req = '0; we = '0;
    sel = '0; addr = '0; wdata = '0;
    @(negedge clk);
    cmp("reset_state", 128'({busy, start, gnt, rvalid, rdata, cwr, caddr_wr, cdata_wr,
                             crd, caddr_rd, csel, err}), 128'(0));
    tick();
    reset = 1'b0;

    // Host start, then a second ready while busy that must be ignored.
    ready = 1'b1;
    q_start.push_back(64'(3'b001));
    tick();
    @(negedge clk);
    cmp("busy_after_ready", 128'(busy), 128'(1'b1));
    tick();
    ready = 1'b0;

    // CONV write.
    req = 3'b001;
    set_eng(0, 1'b1, CSEL_L0, 12'h041, 20'h01310);
    q_gnt.push_back(64'(3'b001));
    q_wr.push_back(64'({12'h041, 20'h01310, CSEL_L0}));
    tick();

    // Ineligible pool request during CONV.
    req = 3'b010;
    set_eng(1, 1'b0, CSEL_L0, 12'h222, 20'h0);
    tick();
    req = 3'b000;
    @(negedge clk);
    cmp("err_after_ineligible_req", 128'(err), 128'(1'b1));
    tick();

    // CONV read issued in the same cycle as done[0].
    req  = 3'b001;
    done = 3'b001;
    set_eng(0, 1'b0, CSEL_L1, 12'h100, 20'h0);
    q_gnt.push_back(64'(3'b001));
    q_rd.push_back(64'({12'h100, CSEL_L1}));
    q_rv.push_back(64'({3'b001, mdata(CSEL_L1, 12'h100)}));
    q_start.push_back(64'(3'b110));
    tick();
    req  = 3'b000;
    done = 3'b000;
    wait_start(3'b110, "pf_start_seen");

    // PF: pool and flatten both reading, grants alternate.
    q_gnt.push_back(64'(3'b010)); q_gnt.push_back(64'(3'b100));
    q_gnt.push_back(64'(3'b010)); q_gnt.push_back(64'(3'b100));
    for (int i = 0; i < 4; i++) begin
      logic [2:0] s;
      s = (i % 2 == 0) ? CSEL_L0 : CSEL_L1;
      q_rd.push_back(64'({12'(i), s}));
      q_rv.push_back(64'({((i % 2 == 0) ? 3'b010 : 3'b100), mdata(s, 12'(i))}));
    end
    p_i = 0; f_i = 0; c_used = 0;
    for (int c = 0; c < 20 && (p_i < 2 || f_i < 2); c++) begin
      req = {f_i < 2, p_i < 2, 1'b0};
      set_eng(1, 1'b0, CSEL_L0, p_addr[p_i % 2], 20'h0);
      set_eng(2, 1'b0, CSEL_L1, f_addr[f_i % 2], 20'h0);
      @(negedge clk);
      if (gnt[1]) p_i++;
      if (gnt[2]) f_i++;
      c_used++;
      @(posedge clk);
      #1;
    end
    cmp("pf_back_to_back_cycles", 128'(c_used), 128'(4));

    // Both PF dones together with one read in flight.
    req  = 3'b010;
    done = 3'b110;
    set_eng(1, 1'b0, CSEL_L0, 12'h010, 20'h0);
    q_gnt.push_back(64'(3'b010));
    q_rd.push_back(64'({12'h010, CSEL_L0}));
    q_rv.push_back(64'({3'b010, mdata(CSEL_L0, 12'h010)}));
    tick();
    req  = 3'b000;
    done = 3'b000;
    @(negedge clk);
    cmp("busy_err_in_drain", 128'({busy, err}), 128'(2'b11));
    @(negedge clk);
    cmp("busy_at_last_rvalid", 128'({busy, rvalid}), 128'({1'b1, 3'b010}));
    @(negedge clk);
    cmp("busy_falls", 128'(busy), 128'(1'b0));

    // Restart, then reset the cycle after a read grant.
    tick();
    ready = 1'b1;
    q_start.push_back(64'(3'b001));
    tick();
    ready = 1'b0;
    tick();
    req = 3'b001;
    set_eng(0, 1'b0, CSEL_L0, 12'h055, 20'h0);
    q_gnt.push_back(64'(3'b001));
    tick();
    req   = 3'b000;
    reset = 1'b1;
    @(negedge clk);
    cmp("reset_midop", 128'({busy, start, gnt, rvalid, rdata, cwr, caddr_wr, cdata_wr,
                             crd, caddr_rd, csel, err}), 128'(0));
    tick();
    tick();
    reset = 1'b0;

    // Fresh job from CONV after reset.
    ready = 1'b1;
    q_start.push_back(64'(3'b001));
    tick();
    ready = 1'b0;
    @(negedge clk);
    cmp("restart_busy_noerr", 128'({busy, err}), 128'(2'b10));
    tick();
    req = 3'b001;
    set_eng(0, 1'b1, CSEL_L1, 12'h7FF, 20'hFFFFF);
    q_gnt.push_back(64'(3'b001));
    q_wr.push_back(64'({12'h7FF, 20'hFFFFF, CSEL_L1}));
    tick();
    req  = 3'b000;
    done = 3'b001;
    q_start.push_back(64'(3'b110));
    tick();
    done = 3'b000;
    wait_start(3'b110, "pf_start_seen_2");
    done = 3'b110;
    tick();
    done = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    cmp("final_idle", 128'({busy, err}), 128'(2'b00));

    cmp("q_gnt_empty",   128'(q_gnt.size()),   128'(0));
    cmp("q_wr_empty",    128'(q_wr.size()),    128'(0));
    cmp("q_rd_empty",    128'(q_rd.size()),    128'(0));
    cmp("q_rv_empty",    128'(q_rv.size()),    128'(0));
    cmp("q_start_empty", 128'(q_start.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_mem_sched.md
Name: layer_mem_sched

Overview:
- Top-level sequencer and shared-port arbiter for the layer-memory subsystem.
- Accepts the host start handshake (`ready`/`busy`) and launches the engines in order: conv engine first (phase CONV), then pool and flatten engines concurrently (phase PF).
- Arbitrates the single layer-memory port (`csel`/`cwr`/`crd`/addresses/data) between engines, one access per cycle, round-robin.
- Sits between the engines and the testbench-side layer memories.

Parameters:
- ADDR_W, 12, layer-memory address width
- DATA_W, 20, layer-memory data width
- SEL_W, 3, memory-select width
- NUM_REQ, 3, requester count. Index 0 = conv, 1 = pool, 2 = flatten. Fixed at 3 for phase mapping.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ready  in  1  host start request
- busy  out  1  job in progress
- start  out  NUM_REQ  one-cycle start pulse per engine
- done  in  NUM_REQ  one-cycle done pulse per engine
- req  in  NUM_REQ  access request per engine; held until granted
- we  in  NUM_REQ  1 = write, 0 = read, per engine
- sel  in  NUM_REQ*SEL_W  packed memory select per engine
- addr  in  NUM_REQ*ADDR_W  packed address per engine
- wdata  in  NUM_REQ*DATA_W  packed write data per engine
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_REQ  one-hot read-return strobe
- rdata  out  DATA_W  read data, valid with rvalid
- cwr  out  1  memory write enable
- caddr_wr  out  ADDR_W  write address
- cdata_wr  out  DATA_W  write data
- crd  out  1  memory read enable
- caddr_rd  out  ADDR_W  read address
- cdata_rd  in  DATA_W  memory read data, valid in the cycle crd is high
- csel  out  SEL_W  memory select
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: all outputs 0 (busy, start, gnt, rvalid, rdata, cwr, crd, addresses, data, csel, err). FSM state IDLE, RR pointer 2 (so requester 0 is searched first).
- FSM: IDLE -> CONV -> PF -> DRAIN -> IDLE.
- IDLE: `ready`=1 -> `busy`<=1, `start[0]` pulses next cycle, go to CONV. `ready` is ignored while `busy`=1.
- CONV: only requester 0 is eligible. `done[0]` -> go to DRAIN_C; when the pipe is empty, pulse `start[1]` and `start[2]` together and enter PF.
- PF: requesters 1 and 2 are eligible. Per-engine sticky done flags; simultaneous `done[1]` and `done[2]` are accepted. When both flags are set -> DRAIN.
- DRAIN: wait until no read is in flight, then `busy`<=0 and return to IDLE. `busy` falls exactly one cycle after the pipe is empty.
- Eligibility violations: `req` or `done` from an ineligible engine gets no grant, sets `err`, and never alters state. `err` is cleared only by reset.
- Arbitration: among eligible asserted `req`, grant the first index after the RR pointer (modulo 3). The pointer updates to the granted index. At most one `gnt` bit per cycle; `gnt`=0 when no eligible req.
- Port timing: grant in cycle T -> registered memory controls in T+1:
  - write: `cwr`=1, `caddr_wr`/`cdata_wr`/`csel` from winner;
  - read: `crd`=1, `caddr_rd`/`csel` from winner;
  - `cwr` and `crd` are never both 1; both are 0 when there is no grant.
- Read return: `cdata_rd` is sampled at the end of T+1; `rdata` and `rvalid[winner]` are asserted in T+2. Fixed latency 2; back-to-back reads are fully pipelined (1 access/cycle).
- In-flight tracking: a 2-stage valid/tag shift register records which engine owns each in-flight read.
- Reset mid-operation: immediate return to the reset state; in-flight reads are discarded and no `rvalid` is produced.

Decomposition:
- Shared package: requester indices (REQ_CONV=0, REQ_POOL=1, REQ_FLAT=2), FSM state encoding, csel constants (CSEL_NONE=0, CSEL_L0=1, CSEL_L1=3).
- One sub-module, `rr_arbiter3`: combinational round-robin pick plus pointer register; inputs eligible-req vector, output one-hot grant.

Test Plan:
- Reset then `ready`=1 for 1 cycle -> `busy`=1 next cycle, `start`=3'b001 one cycle later; a second `ready` while busy -> no effect.
- CONV phase, `req[0]` write `addr`=12'h041, `wdata`=20'h01310, `sel`=1 -> `gnt[0]` same cycle; next cycle `cwr`=1, `caddr_wr`=12'h041, `cdata_wr`=20'h01310, `csel`=3'b001.
- PF phase, `req[1]` and `req[2]` both held reading 12'h000..12'h003 -> grants alternate 1,2,1,2; each `rvalid` arrives 2 cycles after its `gnt` carrying the model data; `crd` high continuously.
- `req[1]` during CONV phase -> no `gnt`, `err`=1 and stays 1; CONV completes normally.
- `done[1]` and `done[2]` in the same cycle with one read in flight -> `busy` falls one cycle after that read's `rvalid`; `start` never re-pulses.
- Assert `reset` the cycle after a read grant -> all outputs 0 immediately, no `rvalid` afterwards; a new `ready` restarts from CONV.
